stream_capture: RTL and testbench

//  Receiving end of the t_en / t_valid / t_out value interface driven by the counter/timer producers.

---
 rtl/stream_cap_pkg.sv | 12 +
 rtl/stream_capture_sync_fifo.sv | 43 ++++
 rtl/stream_capture.sv | 80 ++++++++
 tb/tb_stream_capture.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_cap_pkg.sv
// Shared definitions for the stream capture block: FSM encodings and default word width.
package stream_cap_pkg;

   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2
   } state_e;

endpackage

// File: rtl/stream_capture_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Callers qualify push/pop; count never wraps.
module sync_fifo #(
   parameter  int DEPTH  = 8,
   parameter  int DATA_W = 16,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = AW + 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic [CW-1:0]     count_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;

   assign count_d = count_q + CW'(push_i) - CW'(pop_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

endmodule

// File: rtl/stream_capture.sv
// Capture front end: grants enable to a producer, buffers its words in a FIFO and
// replays them downstream over ready/valid, flagging any word lost to a full FIFO.
module stream_capture
   import stream_cap_pkg::*;
#(
   parameter  int DEPTH  = 8,
   parameter  int DATA_W = DATA_W_DEF,
   localparam int CW     = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic              in_en,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [CW-1:0]     count,
   output logic              overflow,
   output logic              busy
);

   state_e        state_q, state_d;
   logic          in_en_q, in_en_d;
   logic          ovf_q, ovf_d;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          active, full, pop, push, drop, start_acc;

   assign active    = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
   assign full      = (cnt == CW'(DEPTH));
   assign pop       = out_valid && out_ready;
   assign push      = active && in_valid && (!full || pop);
   assign drop      = active && in_valid && full && !pop;
   assign start_acc = (state_q == ST_IDLE) && start;
   assign cnt_nxt   = cnt + CW'(push) - CW'(pop);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (start) state_d = ST_CAPTURE;
         ST_CAPTURE: if (stop)  state_d = ST_DRAIN;
         ST_DRAIN:   if (cnt == '0 && !push) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
      // One slot stays free for the word the producer may already have in flight.
      in_en_d = (state_d == ST_CAPTURE) && (cnt_nxt <= CW'(DEPTH - 2));
      ovf_d   = start_acc ? 1'b0 : (ovf_q | drop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         in_en_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         in_en_q <= in_en_d;
         ovf_q   <= ovf_d;
      end
   end

   sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (in_data),
      .rdata_o (out_data),
      .count_o (cnt)
   );

   assign in_en     = in_en_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (cnt != '0);
   assign count     = cnt;

endmodule

// File: tb/tb_stream_capture.sv
// Bench for stream_capture: directed scenarios plus randomized traffic against a queue-based model.
module tb_stream_capture;
   localparam int DEPTH  = 8;
   localparam int DATA_W = 16;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, stop = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic in_en, out_valid, overflow, busy;
   logic [DATA_W-1:0] out_data;
   logic [CW-1:0] count;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   stream_capture #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .in_en(in_en),
      .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .count(count),
      .overflow(overflow), .busy(busy)
   );

   // Reference model: a queue holds the buffered words; m_st 0=idle 1=capture 2=drain.
   logic [DATA_W-1:0] mq[$];
   int  m_st = 0, m_osz;
   bit  m_en = 0, m_ovf = 0, m_pop, m_push, m_drop, m_act;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete(); m_st = 0; m_en = 0; m_ovf = 0;
      end else begin
         m_osz  = mq.size();
         m_act  = (m_st != 0);
         m_pop  = (m_osz != 0) && out_ready;
         m_push = m_act && in_valid && ((m_osz < DEPTH) || m_pop);
         m_drop = m_act && in_valid && (m_osz == DEPTH) && !m_pop;
         if (m_pop)  void'(mq.pop_front());
         if (m_push) mq.push_back(in_data);
         if (m_st == 0 && start) begin m_st = 1; m_ovf = 0; end
         else if (m_st == 1 && stop) m_st = 2;
         else if (m_st == 2 && m_osz == 0 && !m_push) m_st = 0;
         if (m_drop) m_ovf = 1;
         m_en = (m_st == 1) && (mq.size() <= DEPTH - 2);
      end
   end

   // Producer: raises t_valid one cycle after it sees in_en, counting data upward.
   bit prod_on = 0, last_en = 0;
   logic [DATA_W-1:0] prod_cnt = '0;

   task automatic tick();
      @(negedge clk);
      if (prod_on) begin
         in_valid = last_en;
         if (last_en) begin in_data = prod_cnt; prod_cnt++; end
      end
      last_en = in_en;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 64; i++) begin
         tick();
         if (!busy) begin ok = 1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'($urandom); stop = 1'($urandom); in_valid = 1'($urandom);
         out_ready = 1'($urandom); in_data = 16'($urandom);
         #1;
         n_chk++;
         if ({in_en, out_valid, out_data, count, overflow, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got en=%b ov=%b data=%h cnt=%0d ovf=%b busy=%b, want all 0",
                     in_en, out_valid, out_data, count, overflow, busy);
         end
      end
      @(negedge clk);
      start = 0; stop = 0; in_valid = 0; out_ready = 0; in_data = '0;
      rst = 1;
      repeat (5) tick();
      n_chk++;
      if ({in_en, out_valid, out_data, count, overflow, busy} !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: got en=%b ov=%b data=%h cnt=%0d ovf=%b busy=%b, want all 0",
                  in_en, out_valid, out_data, count, overflow, busy);
      end
   endtask

   task automatic test_start_stop_same();
      bit ok;
      start = 1; stop = 1; tick(); start = 0; stop = 0;
      n_chk++;
      if (busy !== 1'b1 || in_en !== 1'b1) begin
         n_fail++;
         $display("FAIL start_wins: got busy=%b en=%b, want busy=1 en=1", busy, in_en);
      end
      stop = 1; tick(); stop = 0;
      wait_idle(ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL start_wins_idle: busy=%b, want 0", busy); end
   endtask

   task automatic test_basic();
      logic [DATA_W-1:0] exp;
      bit ok;
      exp = 1; prod_cnt = 1; last_en = 0; prod_on = 1; out_ready = 1;
      start = 1; tick(); start = 0;
      repeat (40) begin
         if (out_valid && out_ready) begin
            n_chk++;
            if (out_data !== exp) begin n_fail++; $display("FAIL basic_order: got %0d, want %0d", out_data, exp); end
            exp++;
         end
         tick();
      end
      n_chk++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b, want 0", overflow); end
      ok = 0; stop = 1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid && out_ready) begin
            n_chk++;
            if (out_data !== exp) begin n_fail++; $display("FAIL basic_drain_order: got %0d, want %0d", out_data, exp); end
            exp++;
         end
         if (!busy) begin ok = 1; break; end
         tick(); stop = 0;
      end
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL basic_drain: still busy=%b, want 0", busy); end
      n_chk++;
      if (exp !== prod_cnt) begin n_fail++; $display("FAIL basic_total: got %0d words, want %0d", exp - 1, prod_cnt - 1); end
      prod_on = 0; in_valid = 0;
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] exp;
      bit ok;
      exp = 1; prod_cnt = 1; last_en = 0; prod_on = 1; out_ready = 0;
      start = 1; tick(); start = 0;
      repeat (20) begin
         tick();
         n_chk++;
         if (in_en !== (count <= CW'(DEPTH - 2))) begin
            n_fail++; $display("FAIL bp_en: got en=%b at count=%0d", in_en, count);
         end
      end
      n_chk++;
      if (count !== CW'(DEPTH) || in_en !== 1'b0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL bp_full: got cnt=%0d en=%b ovf=%b, want 8 0 0", count, in_en, overflow);
      end
      out_ready = 1;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (out_valid && out_ready) begin
            n_chk++;
            if (out_data !== exp) begin n_fail++; $display("FAIL bp_order: got %0d, want %0d", out_data, exp); end
            exp++;
         end
         if (!busy) begin ok = 1; break; end
         if (i == 12) stop = 1;
         tick(); stop = 0;
      end
      n_chk++;
      if (!ok || exp < 9) begin n_fail++; $display("FAIL bp_drain: got busy=%b delivered=%0d, want 0 and >=8", busy, exp - 1); end
      prod_on = 0; in_valid = 0;
   endtask

   task automatic test_forced_drop();
      logic [DATA_W-1:0] exp;
      bit ok;
      out_ready = 0; start = 1; tick(); start = 0;
      for (int i = 1; i <= 10; i++) begin in_valid = 1; in_data = 16'(i); tick(); end
      in_valid = 0;
      n_chk++;
      if (count !== CW'(DEPTH) || overflow !== 1'b1 || out_data !== 16'd1) begin
         n_fail++; $display("FAIL drop_full: got cnt=%0d ovf=%b head=%0d, want 8 1 1", count, overflow, out_data);
      end
      repeat (5) tick();
      n_chk++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_sticky: got %b, want 1", overflow); end
      exp = 1; ok = 0; stop = 1; out_ready = 1;
      for (int i = 0; i < 30; i++) begin
         if (out_valid) begin
            n_chk++;
            if (out_data !== exp) begin n_fail++; $display("FAIL drop_order: got %0d, want %0d", out_data, exp); end
            exp++;
         end
         if (!busy) begin ok = 1; break; end
         tick(); stop = 0;
      end
      n_chk++;
      if (!ok || exp !== 16'd9 || overflow !== 1'b1) begin
         n_fail++; $display("FAIL drop_idle: got busy=%b words=%0d ovf=%b, want 0 8 1", busy, exp - 1, overflow);
      end
      start = 1; tick(); start = 0;
      n_chk++;
      if (overflow !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL drop_clear: got ovf=%b busy=%b, want 0 1", overflow, busy);
      end
      stop = 1; tick(); stop = 0;
      wait_idle(ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL drop_end: busy=%b, want 0", busy); end
   endtask

   task automatic test_drain();
      logic [DATA_W-1:0] exp;
      bit ok;
      out_ready = 0; start = 1; tick(); start = 0;
      for (int i = 1; i <= 5; i++) begin in_valid = 1; in_data = 16'(100 + i); tick(); end
      in_valid = 0;
      n_chk++;
      if (count !== CW'(5)) begin n_fail++; $display("FAIL drain_fill: got cnt=%0d, want 5", count); end
      exp = 101; stop = 1; out_ready = 1;
      if (out_valid) begin
         n_chk++;
         if (out_data !== exp) begin n_fail++; $display("FAIL drain_order: got %0d, want %0d", out_data, exp); end
         exp++;
      end
      tick(); stop = 0;
      n_chk++;
      if (in_en !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL drain_en: got en=%b busy=%b, want 0 1", in_en, busy); end
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) begin
            n_chk++;
            if (out_data !== exp) begin n_fail++; $display("FAIL drain_order: got %0d, want %0d", out_data, exp); end
            exp++;
         end
         if (count == '0) begin
            n_chk++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy_hold: got %b, want 1", busy); end
            tick();
            n_chk++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_busy_fall: got %b, want 0", busy); end
            ok = 1; break;
         end
         tick();
      end
      n_chk++;
      if (!ok || exp !== 16'd106) begin n_fail++; $display("FAIL drain_total: got words=%0d done=%b, want 5 1", exp - 101, ok); end
   endtask

   task automatic test_full_pushpop();
      logic [DATA_W-1:0] exp;
      out_ready = 0; start = 1; tick(); start = 0;
      for (int i = 1; i <= 8; i++) begin in_valid = 1; in_data = 16'(i); tick(); end
      n_chk++;
      if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL pp_fill: got cnt=%0d, want 8", count); end
      exp = 1;
      for (int i = 9; i <= 14; i++) begin
         in_valid = 1; in_data = 16'(i); out_ready = 1;
         n_chk++;
         if (out_data !== exp) begin n_fail++; $display("FAIL pp_head: got %0d, want %0d", out_data, exp); end
         exp++;
         tick();
         n_chk++;
         if (count !== CW'(DEPTH) || overflow !== 1'b0) begin
            n_fail++; $display("FAIL pp_count: got cnt=%0d ovf=%b, want 8 0", count, overflow);
         end
      end
      in_valid = 0; out_ready = 0;
      #2 rst = 0;
      #1;
      n_chk++;
      if ({in_en, out_valid, out_data, count, overflow, busy} !== '0) begin
         n_fail++;
         $display("FAIL async_rst: got en=%b ov=%b data=%h cnt=%0d ovf=%b busy=%b, want all 0",
                  in_en, out_valid, out_data, count, overflow, busy);
      end
      @(negedge clk); rst = 1;
      tick();
      n_chk++;
      if ({out_valid, count, busy} !== '0) begin
         n_fail++; $display("FAIL async_rst_after: got ov=%b cnt=%0d busy=%b, want 0", out_valid, count, busy);
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] md;
      bit pen, ok;
      pen = 0; prod_on = 0;
      for (int c = 0; c < 600; c++) begin
         tick();
         md = (mq.size() != 0) ? mq[0] : '0;
         n_chk++;
         if ({out_valid, out_data, count, in_en, overflow, busy} !==
             {mq.size() != 0, md, CW'(mq.size()), m_en, m_ovf, m_st != 0}) begin
            n_fail++;
            $display("FAIL random c=%0d: got ov=%b d=%h cnt=%0d en=%b ovf=%b busy=%b, want ov=%b d=%h cnt=%0d en=%b ovf=%b busy=%b",
                     c, out_valid, out_data, count, in_en, overflow, busy,
                     mq.size() != 0, md, mq.size(), m_en, m_ovf, m_st != 0);
         end
         start     = ($urandom_range(0, 24) == 0);
         stop      = ($urandom_range(0, 29) == 0);
         out_ready = (c % 100 < 60) ? ($urandom_range(0, 3) != 0) : 1'b0;
         in_valid  = (pen && $urandom_range(0, 3) != 0) || ($urandom_range(0, 15) == 0);
         in_data   = 16'($urandom);
         pen       = in_en;
      end
      start = 0; in_valid = 0; out_ready = 1; stop = 1;
      tick(); stop = 0;
      wait_idle(ok);
      n_chk++;
      if (!ok || mq.size() != 0 || m_st != 0) begin
         n_fail++; $display("FAIL random_end: got busy=%b model_size=%0d, want idle and empty", busy, mq.size());
      end
   endtask

   initial begin
      test_reset();
      test_start_stop_same();
      test_basic();
      test_backpressure();
      test_forced_drop();
      test_drain();
      test_full_pushpop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
